// File: rtl/hilo_unit_pkg.sv
// ---------------------------------------------------------------------------
// hilo_unit_pkg
// Shared CPU definitions for the HI/LO multiply/divide unit:
//   - md_op encodings (bit1 = divide, bit0 = signed)
//   - busy latencies for multiply and divide
//   - FSM state encoding
//   - op_latency(): maps an md_op to its busy-period length
// ---------------------------------------------------------------------------
package hilo_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hilo_state_t;

    // Busy-period length for an operation; only the divide bit matters.
    function automatic logic [3:0] op_latency(input logic [1:0] md_op);
        return md_op[1] ? DIV_LAT : MUL_LAT;
    endfunction

endpackage

// File: rtl/hilo_calc.sv
// ---------------------------------------------------------------------------
// hilo_calc
// Purely combinational 64-bit result generator for mult/multu/div/divu.
// Ports:
//   i_md_op  [1:0]   operation select (see hilo_unit_pkg encodings)
//   i_a      [31:0]  rs operand (dividend / multiplicand)
//   i_b      [31:0]  rt operand (divisor / multiplier)
//   o_hi     [31:0]  HI result (product upper half / remainder)
//   o_lo     [31:0]  LO result (product lower half / quotient)
//   o_wr             1 when the result should be committed; 0 for divide by zero
// ---------------------------------------------------------------------------
module hilo_calc
    import hilo_unit_pkg::*;
(
    input  logic [1:0]        i_md_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_wr
);

    logic signed [2*DATA_W-1:0] w_sprod;
    logic        [2*DATA_W-1:0] w_uprod;
    logic signed [DATA_W-1:0]   w_sa;
    logic signed [DATA_W-1:0]   w_sb_safe;
    logic signed [DATA_W-1:0]   w_squot;
    logic signed [DATA_W-1:0]   w_srem;
    logic        [DATA_W-1:0]   w_ub_safe;
    logic        [DATA_W-1:0]   w_uquot;
    logic        [DATA_W-1:0]   w_urem;
    logic                       w_div0;
    logic                       w_ovf;

    // Both operands sign-extended to full product width so the signed
    // multiply yields the exact two's-complement 64-bit result.
    assign w_sprod = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) *
                     $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
    assign w_uprod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

    assign w_div0 = (i_b == '0);
    // Most-negative / -1 overflows the quotient; dividing by +1 instead
    // yields exactly the wanted LO=0x80000000, HI=0.
    assign w_ovf  = (i_a == {1'b1, {(DATA_W-1){1'b0}}}) && (i_b == {DATA_W{1'b1}});

    // A zero divisor is replaced by 1 only to keep the dividers free of X;
    // the result is discarded via o_wr.
    assign w_ub_safe = w_div0 ? {{(DATA_W-1){1'b0}}, 1'b1} : i_b;
    assign w_sb_safe = (w_div0 || w_ovf) ? $signed({{(DATA_W-1){1'b0}}, 1'b1})
                                         : $signed(i_b);
    assign w_sa      = $signed(i_a);

    assign w_uquot = i_a / w_ub_safe;
    assign w_urem  = i_a % w_ub_safe;
    // SystemVerilog signed division truncates toward zero and the remainder
    // carries the sign of the dividend, matching MIPS div semantics.
    assign w_squot = w_sa / w_sb_safe;
    assign w_srem  = w_sa % w_sb_safe;

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        o_wr = 1'b1;
        case (i_md_op)
            MD_MULTU: {o_hi, o_lo} = w_uprod;
            MD_MULT:  {o_hi, o_lo} = w_sprod;
            MD_DIVU: begin
                o_hi = w_urem;
                o_lo = w_uquot;
                o_wr = !w_div0;
            end
            MD_DIV: begin
                o_hi = w_srem;
                o_lo = w_squot;
                o_wr = !w_div0;
            end
            default: begin
                o_hi = '0;
                o_lo = '0;
                o_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hilo_unit.sv
// ---------------------------------------------------------------------------
// hilo_unit
// MIPS-style HI/LO register pair with a fixed-latency multiply/divide unit.
// A start in IDLE captures the full result immediately into pending
// registers, then a down-counter models the unit latency; HI/LO are updated
// only when the counter expires, so the new values appear in the first
// cycle with busy=0.
// Ports:
//   clk       clock, all state on rising edge
//   rst_n     synchronous active-low reset
//   start     mult/multu/div/divu in EX this cycle
//   md_op     00 multu, 01 mult, 10 divu, 11 div
//   a, b      forwarded rs / rt operands
//   mthi      write a to HI (IDLE only)
//   mtlo      write a to LO (IDLE only)
//   mf_sel    0 selects HI, 1 selects LO on hilo_out
//   busy      operation in progress
//   hilo_out  committed HI or LO for mfhi/mflo
// ---------------------------------------------------------------------------
module hilo_unit
    import hilo_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mf_sel,
    output logic        busy,
    output logic [31:0] hilo_out
);

    hilo_state_t       r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_p_hi;
    logic [DATA_W-1:0] r_p_lo;
    logic              r_p_wr;
    logic              r_busy;

    logic [DATA_W-1:0] w_calc_hi;
    logic [DATA_W-1:0] w_calc_lo;
    logic              w_calc_wr;

    hilo_calc u_calc (
        .i_md_op (md_op),
        .i_a     (a),
        .i_b     (b),
        .o_hi    (w_calc_hi),
        .o_lo    (w_calc_lo),
        .o_wr    (w_calc_wr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_p_wr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Operands are sampled only here; later changes on
                        // a/b cannot disturb the pending result.
                        r_p_hi  <= w_calc_hi;
                        r_p_lo  <= w_calc_lo;
                        r_p_wr  <= w_calc_wr;
                        r_cnt   <= op_latency(md_op);
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                    end else begin
                        // mt writes only when no operation is starting.
                        if (mthi) r_hi <= a;
                        if (mtlo) r_lo <= a;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        // Divide by zero keeps the busy period but commits nothing.
                        if (r_p_wr) begin
                            r_hi <= r_p_hi;
                            r_lo <= r_p_lo;
                        end
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign hilo_out = mf_sel ? r_lo : r_hi;

endmodule
